// File: rtl/pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_unit
//
// Pipelined control unit for a 5-stage MIPS core. It decodes the instruction
// held in IF/ID into a control bundle, then carries that bundle through the
// ID/EX, EX/MEM and MEM/WB registers. It also:
//   - detects load-use and mult/div hazards and stalls IF/ID,
//   - squashes IF/ID on a taken branch or jump,
//   - produces the EX-stage operand forwarding selects.
//
// Optional feature (macro PIPE_CTRL_PERF_CNT_EN): saturating stall and flush
// event counters (stall_cnt, flush_cnt). When the macro is undefined these
// ports and counters do not exist.
//
// Parameters:
//   AW     register-address width
//   MD_LAT mult/div busy cycles after issue (1..255)
//   CNT_W  width of the optional performance counters
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  IF/ID holds a real instruction
//   id_opcode, id_func        Instr[31:26], Instr[5:0]
//   id_rs, id_rt, id_rd       Instr[25:21], Instr[20:16], Instr[15:11]
//   id_br_taken               branch/jump resolved taken in ID
//   stall_if_id               hold PC and IF/ID (combinational)
//   flush_if_id               squash IF/ID (combinational)
//   ex_mem_rd, ex_reg_wr      ID/EX control
//   ex_wr_reg, ex_rs, ex_rt   ID/EX register addresses
//   mem_mem_rd, mem_mem_wt,
//   mem_reg_wr, mem_wr_reg    EX/MEM control and destination
//   wb_reg_wr, wb_wr_reg      MEM/WB write enable and destination
//   wb_mem_to_reg             00 link (PC+8), 01 ALU, 10 memory
//   fwd_a, fwd_b              EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   md_busy                   mult/div unit busy
//   stall_cnt, flush_cnt      event counters (only with PIPE_CTRL_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int AW     = 5,
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_func,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          id_br_taken,
    output logic          stall_if_id,
    output logic          flush_if_id,
    output logic          ex_mem_rd,
    output logic          ex_reg_wr,
    output logic [AW-1:0] ex_wr_reg,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic          mem_mem_rd,
    output logic          mem_mem_wt,
    output logic          mem_reg_wr,
    output logic [AW-1:0] mem_wr_reg,
    output logic          wb_reg_wr,
    output logic [AW-1:0] wb_wr_reg,
    output logic [1:0]    wb_mem_to_reg,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          md_busy
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // ------------------------------------------------------------------
    // ID-stage decode
    // ------------------------------------------------------------------
    logic          op_r;
    logic          is_jr;
    logic          is_jalr;
    logic          is_jal;
    logic          is_md;
    logic          is_mfhilo;
    logic          is_branch;
    logic          dec_mem_rd;
    logic          dec_mem_wt;
    logic          dec_reg_wr;
    logic [AW-1:0] dec_wr_reg;
    logic [1:0]    dec_mem_to_reg;

    always_comb begin
        op_r       = (id_opcode == 6'h00);
        is_jr      = op_r && (id_func == 6'h08);
        is_jalr    = op_r && (id_func == 6'h09);
        is_jal     = (id_opcode == 6'h03);
        // mult, multu, div, divu occupy func 0x18..0x1B
        is_md      = op_r && (id_func[5:2] == 4'b0110);
        is_mfhilo  = op_r && ((id_func == 6'h10) || (id_func == 6'h12));
        // j, REGIMM and beq/bne/blez/bgtz (0x04..0x07)
        is_branch  = (id_opcode == 6'h01) || (id_opcode == 6'h02) ||
                     (id_opcode[5:2] == 4'b0001);
        dec_mem_rd = (id_opcode == 6'h20) || (id_opcode == 6'h21) ||
                     (id_opcode == 6'h23) || (id_opcode == 6'h24) ||
                     (id_opcode == 6'h25);
        dec_mem_wt = (id_opcode == 6'h28) || (id_opcode == 6'h29) ||
                     (id_opcode == 6'h2B);
        dec_reg_wr = !(is_jr || dec_mem_wt || is_branch || is_md);

        // Non-writing instructions carry destination 0 so that hazard and
        // forwarding compares never see a stale address.
        if (!dec_reg_wr) begin
            dec_wr_reg = '0;
        end else if (is_jal) begin
            dec_wr_reg = AW'(5'd31);
        end else if (op_r) begin
            dec_wr_reg = id_rd;
        end else begin
            dec_wr_reg = id_rt;
        end

        if (is_jal || is_jalr) begin
            dec_mem_to_reg = 2'b00;
        end else if (dec_mem_rd) begin
            dec_mem_to_reg = 2'b10;
        end else begin
            dec_mem_to_reg = 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers not exposed as ports
    // ------------------------------------------------------------------
    logic       ex_mem_wt;
    logic [1:0] ex_mem_to_reg;
    logic [1:0] mem_mem_to_reg;
    logic [7:0] md_cnt;

    // ------------------------------------------------------------------
    // Hazards, stall and flush
    // ------------------------------------------------------------------
    logic load_use;
    logic md_hazard;
    logic md_issue;
    logic [7:0] md_cnt_next;

    always_comb begin
        load_use    = id_valid && ex_mem_rd && (ex_wr_reg != '0) &&
                      ((ex_wr_reg == id_rs) || (ex_wr_reg == id_rt));
        md_hazard   = id_valid && md_busy && (is_md || is_mfhilo);
        stall_if_id = !rst && (load_use || md_hazard);
        // Stall wins; the branch stays in ID and is re-evaluated next cycle.
        flush_if_id = !rst && id_br_taken && id_valid && !stall_if_id;
        md_issue    = id_valid && is_md && !stall_if_id;

        if (md_issue) begin
            md_cnt_next = 8'(MD_LAT);
        end else if (md_cnt != 8'd0) begin
            md_cnt_next = md_cnt - 8'd1;
        end else begin
            md_cnt_next = 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selects for the instruction in EX (EX/MEM has priority)
    // ------------------------------------------------------------------
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_wr && (mem_wr_reg != '0) && (mem_wr_reg == ex_rs)) begin
            fwd_a = 2'b01;
        end else if (wb_reg_wr && (wb_wr_reg != '0) && (wb_wr_reg == ex_rs)) begin
            fwd_a = 2'b10;
        end
        if (mem_reg_wr && (mem_wr_reg != '0) && (mem_wr_reg == ex_rt)) begin
            fwd_b = 2'b01;
        end else if (wb_reg_wr && (wb_wr_reg != '0) && (wb_wr_reg == ex_rt)) begin
            fwd_b = 2'b10;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers; advance every cycle (no downstream backpressure)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_rd      <= 1'b0;
            ex_mem_wt      <= 1'b0;
            ex_reg_wr      <= 1'b0;
            ex_wr_reg      <= '0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_mem_to_reg  <= 2'b00;
            mem_mem_rd     <= 1'b0;
            mem_mem_wt     <= 1'b0;
            mem_reg_wr     <= 1'b0;
            mem_wr_reg     <= '0;
            mem_mem_to_reg <= 2'b00;
            wb_reg_wr      <= 1'b0;
            wb_wr_reg      <= '0;
            wb_mem_to_reg  <= 2'b00;
            md_cnt         <= 8'd0;
            md_busy        <= 1'b0;
        end else begin
            if (stall_if_id || !id_valid) begin
                ex_mem_rd     <= 1'b0;
                ex_mem_wt     <= 1'b0;
                ex_reg_wr     <= 1'b0;
                ex_wr_reg     <= '0;
                ex_rs         <= '0;
                ex_rt         <= '0;
                ex_mem_to_reg <= 2'b00;
            end else begin
                ex_mem_rd     <= dec_mem_rd;
                ex_mem_wt     <= dec_mem_wt;
                ex_reg_wr     <= dec_reg_wr;
                ex_wr_reg     <= dec_wr_reg;
                ex_rs         <= id_rs;
                ex_rt         <= id_rt;
                ex_mem_to_reg <= dec_mem_to_reg;
            end
            mem_mem_rd     <= ex_mem_rd;
            mem_mem_wt     <= ex_mem_wt;
            mem_reg_wr     <= ex_reg_wr;
            mem_wr_reg     <= ex_wr_reg;
            mem_mem_to_reg <= ex_mem_to_reg;
            wb_reg_wr      <= mem_reg_wr;
            wb_wr_reg      <= mem_wr_reg;
            wb_mem_to_reg  <= mem_mem_to_reg;
            md_cnt         <= md_cnt_next;
            // Registered copy of (md_cnt != 0) so md_busy comes from a flop.
            md_busy        <= (md_cnt_next != 8'd0);
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_if_id && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_if_id && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_unit
//
// Self-checking bench for pipe_ctrl_unit (AW=5, MD_LAT=4). A reference model
// keeps the in-flight instructions as a three-entry array of decoded bundles
// (EX, MEM, WB) and tracks the mult/div unit as "busy until cycle N".
// Directed scenarios come first, then randomized instruction streams. The
// IF/ID contents are held while the model predicts a stall, as a real front
// end would do.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          id_valid;
    logic [5:0]    id_opcode;
    logic [5:0]    id_func;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [AW-1:0] id_rd;
    logic          id_br_taken;
    logic          stall_if_id;
    logic          flush_if_id;
    logic          ex_mem_rd;
    logic          ex_reg_wr;
    logic [AW-1:0] ex_wr_reg;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic          mem_mem_rd;
    logic          mem_mem_wt;
    logic          mem_reg_wr;
    logic [AW-1:0] mem_wr_reg;
    logic          wb_reg_wr;
    logic [AW-1:0] wb_wr_reg;
    logic [1:0]    wb_mem_to_reg;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          md_busy;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    pipe_ctrl_unit #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_func       (id_func),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_br_taken   (id_br_taken),
        .stall_if_id   (stall_if_id),
        .flush_if_id   (flush_if_id),
        .ex_mem_rd     (ex_mem_rd),
        .ex_reg_wr     (ex_reg_wr),
        .ex_wr_reg     (ex_wr_reg),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_mem_rd    (mem_mem_rd),
        .mem_mem_wt    (mem_mem_wt),
        .mem_reg_wr    (mem_reg_wr),
        .mem_wr_reg    (mem_wr_reg),
        .wb_reg_wr     (wb_reg_wr),
        .wb_wr_reg     (wb_wr_reg),
        .wb_mem_to_reg (wb_mem_to_reg),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .md_busy       (md_busy)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          mem_rd;
        logic          mem_wt;
        logic          reg_wr;
        logic [AW-1:0] wr_reg;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [1:0]    m2r;
    } bundle_t;

    bundle_t pipe_q[3];     // 0 = EX, 1 = MEM, 2 = WB
    int      cyc;
    int      busy_until;    // mult/div busy while cyc < busy_until
    int      exp_stall_cnt;
    int      exp_flush_cnt;
    logic    last_stall;

    int n_pass;
    int n_checks;

    function automatic bundle_t decode(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                       input logic [AW-1:0] rd);
        bundle_t b;
        logic    r0;
        r0       = (op == 6'h00);
        b.mem_rd = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        b.mem_wt = op inside {6'h28, 6'h29, 6'h2B};
        b.reg_wr = 1'b1;
        if ((r0 && fn == 6'h08) || b.mem_wt ||
            (op inside {6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07}) ||
            (r0 && (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B})))
            b.reg_wr = 1'b0;
        if (!b.reg_wr)       b.wr_reg = 5'd0;
        else if (op == 6'h03) b.wr_reg = 5'd31;
        else if (r0)          b.wr_reg = rd;
        else                  b.wr_reg = rt;
        if (op == 6'h03 || (r0 && fn == 6'h09)) b.m2r = 2'b00;
        else if (b.mem_rd)                      b.m2r = 2'b10;
        else                                    b.m2r = 2'b01;
        b.rs = rs;
        b.rt = rt;
        return b;
    endfunction

    function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'h00) && (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
        if (pipe_q[1].reg_wr && pipe_q[1].wr_reg != 0 && pipe_q[1].wr_reg == src) return 2'b01;
        if (pipe_q[2].reg_wr && pipe_q[2].wr_reg != 0 && pipe_q[2].wr_reg == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe_q[i] = '0;
        busy_until    = 0;
        cyc           = 0;
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
        last_stall    = 1'b0;
    endtask

    // ---------------- scoreboard compare ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- driver: one cycle ----------------
    // Called at the negedge; checks every output before the next posedge,
    // then advances the model across that edge.
    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic br);
        logic    busy, lu, mdh, st, fl;
        bundle_t nb;
        id_valid = v; id_opcode = op; id_func = fn;
        id_rs = rs; id_rt = rt; id_rd = rd; id_br_taken = br;
        #1;
        busy = (cyc < busy_until);
        lu   = v && pipe_q[0].mem_rd && pipe_q[0].wr_reg != 0 &&
               (pipe_q[0].wr_reg == rs || pipe_q[0].wr_reg == rt);
        mdh  = v && busy && (is_md_op(op, fn) || (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)));
        st   = lu || mdh;
        fl   = br && v && !st;

        check("stall_if_id", stall_if_id, st);
        check("flush_if_id", flush_if_id, fl);
        check("fwd_a", fwd_a, model_fwd(pipe_q[0].rs));
        check("fwd_b", fwd_b, model_fwd(pipe_q[0].rt));
        check("md_busy", md_busy, busy);
        check("ex_mem_rd", ex_mem_rd, pipe_q[0].mem_rd);
        check("ex_reg_wr", ex_reg_wr, pipe_q[0].reg_wr);
        check("ex_wr_reg", ex_wr_reg, pipe_q[0].wr_reg);
        check("ex_rs", ex_rs, pipe_q[0].rs);
        check("ex_rt", ex_rt, pipe_q[0].rt);
        check("mem_mem_rd", mem_mem_rd, pipe_q[1].mem_rd);
        check("mem_mem_wt", mem_mem_wt, pipe_q[1].mem_wt);
        check("mem_reg_wr", mem_reg_wr, pipe_q[1].reg_wr);
        check("mem_wr_reg", mem_wr_reg, pipe_q[1].wr_reg);
        check("wb_reg_wr", wb_reg_wr, pipe_q[2].reg_wr);
        check("wb_wr_reg", wb_wr_reg, pipe_q[2].wr_reg);
        check("wb_mem_to_reg", wb_mem_to_reg, pipe_q[2].m2r);
`ifdef PIPE_CTRL_PERF_CNT_EN
        check("stall_cnt", stall_cnt, exp_stall_cnt);
        check("flush_cnt", flush_cnt, exp_flush_cnt);
`endif

        @(posedge clk);
        nb = (st || !v) ? bundle_t'(0) : decode(op, fn, rs, rt, rd);
        if (v && !st && is_md_op(op, fn)) busy_until = cyc + MD_LAT + 1;
        pipe_q[2] = pipe_q[1];
        pipe_q[1] = pipe_q[0];
        pipe_q[0] = nb;
        cyc++;
        if (st) exp_stall_cnt++;
        if (fl) exp_flush_cnt++;
        last_stall = st;
        @(negedge clk);
    endtask

    // Keep an instruction in IF/ID until it leaves (bounded wait).
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] rd, input logic br);
        int guard;
        guard = 0;
        step(1'b1, op, fn, rs, rt, rd, br);
        while (last_stall && guard < 300) begin
            step(1'b1, op, fn, rs, rt, rd, br);
            guard++;
        end
        if (last_stall) begin
            n_checks++;
            $display("FAIL issue_bound stall still high after %0d cycles, required release", guard);
        end
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Apply reset with a busy-looking IF/ID and check every output is 0.
    task automatic do_reset();
        rst = 1'b1;
        id_valid = 1'b1; id_opcode = 6'h00; id_func = 6'h12;
        id_rs = 5'd3; id_rt = 5'd3; id_rd = 5'd3; id_br_taken = 1'b1;
        @(posedge clk);
        #1;
        check("rst_stall", stall_if_id, 1'b0);
        check("rst_flush", flush_if_id, 1'b0);
        check("rst_md_busy", md_busy, 1'b0);
        check("rst_fwd", {fwd_a, fwd_b}, 4'b0);
        check("rst_ex", {ex_mem_rd, ex_reg_wr, ex_wr_reg, ex_rs, ex_rt}, 17'b0);
        check("rst_mem", {mem_mem_rd, mem_mem_wt, mem_reg_wr, mem_wr_reg}, 8'b0);
        check("rst_wb", {wb_reg_wr, wb_wr_reg, wb_mem_to_reg}, 8'b0);
`ifdef PIPE_CTRL_PERF_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Random instruction from a mix that exercises every decode class.
    task automatic rand_issue();
        logic [5:0] op, fn;
        logic [AW-1:0] rs, rt, rd;
        logic br;
        rs = AW'($urandom_range(0, 7));
        rt = AW'($urandom_range(0, 7));
        rd = AW'($urandom_range(0, 7));
        fn = 6'h20;
        case ($urandom_range(0, 15))
            0:  begin op = 6'h00; fn = 6'h20; end
            1:  begin op = 6'h00; fn = 6'h22; end
            2:  begin op = 6'h00; fn = 6'h08; end
            3:  begin op = 6'h00; fn = 6'h09; end
            4:  begin op = 6'h00; fn = 6'(6'h18 + $urandom_range(0, 3)); end
            5:  begin op = 6'h00; fn = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12; end
            6:  op = 6'h23;
            7:  op = 6'h20;
            8:  op = 6'h25;
            9:  op = 6'h2B;
            10: op = 6'h28;
            11: op = 6'h04;
            12: op = 6'h02;
            13: op = 6'h03;
            14: op = 6'h01;
            default: op = 6'h08;
        endcase
        br = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) == 0) bubble(1);
        else issue(op, fn, rs, rt, rd, br);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_pass = 0;
        n_checks = 0;
        rst = 1'b1;
        id_valid = 1'b0; id_opcode = 6'h00; id_func = 6'h00;
        id_rs = '0; id_rt = '0; id_rd = '0; id_br_taken = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // lw $8,0($1) then add $9,$8,$1: one stall, then MEM/WB forward
        issue(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        issue(6'h00, 6'h20, 5'd8, 5'd1, 5'd9, 1'b0);
        bubble(3);

        // sub $3 (older) then add $3, consumer reads $3: EX/MEM wins
        issue(6'h00, 6'h22, 5'd4, 5'd5, 5'd3, 1'b0);
        issue(6'h00, 6'h20, 5'd6, 5'd7, 5'd3, 1'b0);
        issue(6'h00, 6'h20, 5'd3, 5'd3, 5'd10, 1'b0);
        bubble(3);

        // writes to $0 and reads of $0 never forward
        issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 1'b0);
        issue(6'h00, 6'h20, 5'd0, 5'd0, 5'd11, 1'b0);
        bubble(3);

        // taken beq without hazard, then taken beq behind a load-use
        issue(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
        issue(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        issue(6'h04, 6'h00, 5'd8, 5'd0, 5'd0, 1'b1);
        bubble(2);

        // mult then mflo: mflo held while the unit is busy
        issue(6'h00, 6'h18, 5'd2, 5'd3, 5'd0, 1'b0);
        issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd4, 1'b0);
        bubble(3);

        // back-to-back mult/div: second one waits for the first
        issue(6'h00, 6'h1A, 5'd2, 5'd3, 5'd0, 1'b0);
        issue(6'h00, 6'h19, 5'd2, 5'd3, 5'd0, 1'b0);
        issue(6'h00, 6'h10, 5'd0, 5'd0, 5'd5, 1'b0);
        bubble(3);

        // reset two cycles after a mult issue clears everything in flight
        issue(6'h00, 6'h18, 5'd2, 5'd3, 5'd0, 1'b0);
        issue(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        do_reset();
        issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd4, 1'b0);
        bubble(3);

`ifdef PIPE_CTRL_PERF_CNT_EN
        // counters from a known start: mult+mflo and one taken jump
        do_reset();
        issue(6'h00, 6'h18, 5'd2, 5'd3, 5'd0, 1'b0);
        issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd4, 1'b0);
        issue(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1);
        bubble(1);
`endif

        // randomized streams with occasional resets
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 150; i++) rand_issue();
            do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
